// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port synchronous data memory: the CPU has priority,
// and a starvation counter forces a one-cycle grant to a peripheral that has waited too long.
module dmem_arbiter #(
  parameter int AW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_stall,
  output logic [31:0]   cpu_rdata,
  input  logic          per_req,
  input  logic          per_we,
  input  logic [31:0]   per_addr,
  input  logic [31:0]   per_wdata,
  output logic          per_gnt,
  output logic          per_valid,
  output logic [31:0]   per_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    PER_RD = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  owner_e      owner_q, owner_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] per_rdata_q, per_rdata_d;
  logic        cpu_gnt_s, per_gnt_s, per_starved_s;
  logic        unused_s;

  // Byte-lane and out-of-range address bits are deliberately dropped (memory wraps).
  assign unused_s = ^{cpu_addr[31:AW+2], cpu_addr[1:0], per_addr[31:AW+2], per_addr[1:0]};

  // Grant selection; nothing is granted while reset is held low.
  always_comb begin
    per_starved_s = per_req && (wait_q >= STARVE_LIM);
    cpu_gnt_s     = 1'b0;
    per_gnt_s     = 1'b0;
    if (!reset) begin
      cpu_gnt_s = 1'b0;
      per_gnt_s = 1'b0;
    end else if (per_starved_s) begin
      per_gnt_s = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt_s = 1'b1;
    end else if (per_req) begin
      per_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s = 1'b0;
      per_gnt_s = 1'b0;
    end
  end

  // Memory port mux and handshake outputs.
  always_comb begin
    mem_en    = cpu_gnt_s | per_gnt_s;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0000_0000;
    if (cpu_gnt_s) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[AW+1:2];
      mem_wdata = cpu_wdata;
    end else if (per_gnt_s) begin
      mem_we    = per_we;
      mem_addr  = per_addr[AW+1:2];
      mem_wdata = per_wdata;
    end else begin
      mem_we    = 1'b0;
    end
    cpu_stall = cpu_req & ~cpu_gnt_s & reset;
    per_gnt   = per_gnt_s;
  end

  // Next-state: wait counter, read owner, and read-data hold registers.
  always_comb begin
    wait_d      = wait_q;
    owner_d     = IDLE;
    cpu_rdata_d = cpu_rdata_q;
    per_rdata_d = per_rdata_q;
    if (!per_req || per_gnt_s) begin
      wait_d = 4'd0;
    end else if (wait_q != 4'd15) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
    if (cpu_gnt_s && !cpu_we) begin
      owner_d = CPU_RD;
    end else if (per_gnt_s && !per_we) begin
      owner_d = PER_RD;
    end else begin
      owner_d = IDLE;
    end
    case (owner_q)
      CPU_RD:  cpu_rdata_d = mem_rdata;
      PER_RD:  per_rdata_d = mem_rdata;
      default: begin
        cpu_rdata_d = cpu_rdata_q;
        per_rdata_d = per_rdata_q;
      end
    endcase
  end

  // Returning read data is forwarded in the cycle it arrives, then held.
  always_comb begin
    per_valid = (owner_q == PER_RD);
    cpu_rdata = (owner_q == CPU_RD) ? mem_rdata : cpu_rdata_q;
    per_rdata = (owner_q == PER_RD) ? mem_rdata : per_rdata_q;
  end

  // State registers; reset discards any read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= IDLE;
      wait_q      <= 4'd0;
      cpu_rdata_q <= 32'h0000_0000;
      per_rdata_q <= 32'h0000_0000;
    end else begin
      owner_q     <= owner_d;
      wait_q      <= wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      per_rdata_q <= per_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM on the memory port.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        per_req, per_we;
  logic [31:0] per_addr, per_wdata;
  logic        per_gnt, per_valid;
  logic [31:0] per_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ram [0:255];

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.AW(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_gnt(per_gnt), .per_valid(per_valid), .per_rdata(per_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read-first synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    per_req = 1'b1; per_we = 1'b0; per_addr = 32'h0; per_wdata = 32'h0;
    #2;
    chk("rst_mem_en",    {31'd0, mem_en},    32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_per_gnt",   {31'd0, per_gnt},   32'd0);
    chk("rst_per_valid", {31'd0, per_valid}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_per_rdata", per_rdata, 32'h0);
    cyc();
    cyc();
    cpu_req = 1'b0; per_req = 1'b0;
    reset = 1'b1;

    // Preload word 4 through a CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_mem_en",    {31'd0, mem_en},    32'd1);
    chk("wr_mem_we",    {31'd0, mem_we},    32'd1);
    chk("wr_mem_addr",  {24'd0, mem_addr},  32'd4);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    cyc();

    // Lone peripheral read of 0x10.
    cpu_req = 1'b0; cpu_we = 1'b0;
    per_req = 1'b1; per_we = 1'b0; per_addr = 32'h10;
    #1;
    chk("pr_gnt",      {31'd0, per_gnt},   32'd1);
    chk("pr_mem_addr", {24'd0, mem_addr},  32'd4);
    chk("pr_mem_we",   {31'd0, mem_we},    32'd0);
    chk("pr_valid_n",  {31'd0, per_valid}, 32'd0);
    cyc();
    per_req = 1'b0;
    #1;
    chk("pr_valid",   {31'd0, per_valid}, 32'd1);
    chk("pr_rdata",   per_rdata, 32'hDEAD_BEEF);
    chk("pr_gnt_off", {31'd0, per_gnt},   32'd0);
    chk("pr_mem_off", {31'd0, mem_en},    32'd0);
    cyc();
    chk("pr_valid_pulse", {31'd0, per_valid}, 32'd0);
    chk("pr_rdata_hold",  per_rdata, 32'hDEAD_BEEF);

    // CPU writes 0x64 to 0x20, peripheral reads it back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h64;
    cyc();
    chk("cw_no_valid", {31'd0, per_valid}, 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    per_req = 1'b1; per_we = 1'b0; per_addr = 32'h20;
    #1;
    chk("cw_per_gnt", {31'd0, per_gnt}, 32'd1);
    cyc();
    per_req = 1'b0;
    #1;
    chk("cw_per_rdata", per_rdata, 32'h64);

    // CPU read of word 4.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    chk("cr_stall", {31'd0, cpu_stall}, 32'd0);
    cyc();
    cpu_req = 1'b0;
    #1;
    chk("cr_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("cr_no_per_valid", {31'd0, per_valid}, 32'd0);
    cyc();

    // Sustained contention: peripheral wins every fifth cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    per_req = 1'b1; per_we = 1'b0; per_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("ct_per_gnt_%0d", i),   {31'd0, per_gnt},   {31'd0, (i == 4 || i == 9)});
      chk($sformatf("ct_stall_%0d", i),     {31'd0, cpu_stall}, {31'd0, (i == 4 || i == 9)});
      chk($sformatf("ct_per_valid_%0d", i), {31'd0, per_valid}, {31'd0, (i == 5)});
      if (i == 5) chk("ct_per_rdata", per_rdata, 32'hDEAD_BEEF);
      if (i >= 1) chk($sformatf("ct_cpu_rdata_%0d", i), cpu_rdata, 32'h64);
      cyc();
    end
    cpu_req = 1'b0; per_req = 1'b0;
    cyc();

    // Peripheral withdraws after two denied cycles; its wait count must restart.
    cpu_req = 1'b1;
    per_req = 1'b1; per_we = 1'b1; per_addr = 32'h30; per_wdata = 32'h1234;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("wd_no_gnt_%0d", i), {31'd0, per_gnt}, 32'd0);
      chk($sformatf("wd_mem_addr_%0d", i), {24'd0, mem_addr}, 32'd8);
      cyc();
    end
    per_req = 1'b0;
    #1;
    chk("wd_drop_gnt", {31'd0, per_gnt}, 32'd0);
    chk("wd_drop_we",  {31'd0, mem_we},  32'd0);
    cyc();
    per_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("wd_regnt_%0d", i), {31'd0, per_gnt}, {31'd0, (i == 4)});
      cyc();
    end
    cpu_req = 1'b0; per_req = 1'b0; per_we = 1'b0;
    cyc();

    // Address wrap.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h400; cpu_wdata = 32'h55AA;
    #1;
    chk("wrap_mem_addr", {24'd0, mem_addr}, 32'd0);
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc();

    // Reset during the cycle a peripheral read returns.
    per_req = 1'b1; per_we = 1'b0; per_addr = 32'h10;
    cyc();
    per_req = 1'b0;
    #1;
    chk("mr_valid_pre", {31'd0, per_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_valid",     {31'd0, per_valid}, 32'd0);
    chk("mr_per_rdata", per_rdata, 32'h0);
    chk("mr_cpu_rdata", cpu_rdata, 32'h0);
    chk("mr_mem_en",    {31'd0, mem_en},    32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("mr_post_valid_0", {31'd0, per_valid}, 32'd0);
    cyc();
    chk("mr_post_valid_1", {31'd0, per_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL provide parameter AW, default 8, meaning word-address width of the shared data memory.
REQ-002 SHALL provide parameter STARVE_LIMIT, default 4, meaning consecutive denied peripheral cycles before the peripheral is forced a grant (range 1..15).
REQ-003 SHALL provide port clk  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide cpu_req  input  1  CPU requests a data access this cycle.
REQ-006 SHALL provide cpu_we  input  1  CPU access is a write.
REQ-007 SHALL provide cpu_addr  input  32  CPU byte address.
REQ-008 SHALL provide cpu_wdata  input  32  CPU write data.
REQ-009 SHALL provide cpu_stall  output  1  CPU request not served this cycle; CPU holds PC and request.
REQ-010 SHALL provide cpu_rdata  output  32  CPU read data.
REQ-011 SHALL provide per_req, per_we  input  1 each  peripheral request and write flag.
REQ-012 SHALL provide per_addr, per_wdata  input  32 each  peripheral byte address and write data.
REQ-013 SHALL provide per_gnt  output  1  one-cycle pulse: peripheral access issued to memory.
REQ-014 SHALL provide per_valid  output  1  one-cycle pulse: per_rdata holds read result.
REQ-015 SHALL provide per_rdata  output  32  peripheral read data.
REQ-016 SHALL provide mem_en, mem_we  output  1 each  memory enable and write enable.
REQ-017 SHALL provide mem_addr  output  AW  word address (byte address bits [AW+1:2]).
REQ-018 SHALL provide mem_wdata  output  32 / mem_rdata  input  32  memory data; synchronous read, 1-cycle latency.

Function
REQ-019 Each cycle SHALL grant at most one requester; grant drives mem_en=1 and muxes that requester's we/addr/wdata to memory; no grant -> mem_en=0, mem_we=0.
REQ-020 Default priority SHALL be CPU over peripheral.
REQ-021 A 4-bit wait counter SHALL increment each cycle per_req=1 and peripheral not granted, saturate at 15, and clear on per_gnt or per_req=0.
REQ-022 When wait counter >= STARVE_LIMIT and per_req=1, the peripheral SHALL be granted over the CPU for exactly one cycle.
REQ-023 cpu_stall SHALL equal cpu_req AND NOT CPU-granted, combinational in the same cycle.
REQ-024 per_gnt SHALL be combinational, asserted in the cycle the peripheral access is presented to memory.
REQ-025 Peripheral SHALL hold per_req, per_we, per_addr, per_wdata stable until per_gnt; per_req dropped before grant withdraws the request with no memory access.
REQ-026 A registered owner FSM (IDLE, CPU_RD, PER_RD) SHALL record the read granted in the previous cycle: next = CPU_RD on CPU read grant, PER_RD on peripheral read grant, else IDLE.
REQ-027 In PER_RD, per_valid SHALL be 1 and per_rdata = mem_rdata; otherwise per_valid=0, per_rdata holds last value.
REQ-028 In CPU_RD, cpu_rdata SHALL equal mem_rdata; the CPU samples it the cycle after a non-stalled read.
REQ-029 Writes SHALL produce no valid pulse; write data commits at the grant edge.
REQ-030 Back-to-back grants SHALL be allowed every cycle; a new grant and a returning read in the same cycle are independent.
REQ-031 Address bits [1:0] and bits above AW+1 SHALL be ignored (wrap within memory).

Reset
REQ-032 While reset=0: mem_en=0, mem_we=0, cpu_stall=0, per_gnt=0, per_valid=0, owner=IDLE, wait counter=0, cpu_rdata=0, per_rdata=0.
REQ-033 Reset asserted mid-access SHALL discard any outstanding read; no per_valid after reset release until a new grant.

Verification
REQ-034 Only per_req=1, per_we=0, per_addr=0x10, mem word 4=0xDEADBEEF -> per_gnt cycle N, mem_addr=4, per_valid and per_rdata=0xDEADBEEF cycle N+1.
REQ-035 cpu_req and per_req both held 1, STARVE_LIMIT=4 -> CPU granted 4 cycles, peripheral granted 5th cycle with cpu_stall=1 that cycle only, pattern repeats.
REQ-036 CPU write addr 0x20 data 0x64 then peripheral read addr 0x20 -> per_rdata=0x64 (100).
REQ-037 per_req raised for 2 cycles under CPU contention then dropped -> no per_gnt, no mem access, wait counter back to 0.
REQ-038 reset=0 asserted in PER_RD cycle -> per_valid=0 immediately, all outputs at reset values, no per_valid after release.
REQ-039 Address 0x400 with AW=8 -> mem_addr=0 (wrap).
